mem_1r1w_arbiter: RTL and testbench

Shares one `mem_1r1w_masked` instance (32 x 64-bit, 8-bit byte-mask granularity, 1-cycle read latency) between `N_REQ` requesters. Write and read ports are arbitrated independently, each round-robin. A same-address read/write interlock guarantees every read returns post-write data. An anti-starvation counter bounds how long a read can be held off by colliding writes.

---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/mem_1r1w_masked.sv | 39 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mem_1r1w_arbiter.sv | 118 +++++++++++
 tb/tb_mem_1r1w_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Purpose: shared constants for the 1R1W memory arbiter.
//   N_REQ_MAX : largest supported requester count
//   PTR_W     : width of the round-robin pointers (covers N_REQ_MAX)
//   BLOCK_THR : withheld-read count at which a colliding read wins over the write
package mem_arb_pkg;
  localparam int          N_REQ_MAX = 4;
  localparam int          PTR_W     = 2;
  localparam logic [1:0]  BLOCK_THR = 2'd2;
endpackage

// File: rtl/mem_1r1w_masked.sv
// Purpose: 1-read 1-write memory with byte-granular write mask and a
// registered (1-cycle) read. A same-cycle read of the written address
// returns the old contents.
// Ports:
//   clk_i             clock
//   we_i/waddr_i      write enable / address
//   wdata_i/wmask_i   write data / byte enables
//   re_i/raddr_i      read enable / address
//   rdata_o           read data, valid the cycle after re_i
module mem_1r1w_masked #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (wmask_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin arbiter. Grants the first requester at
// or after the pointer and reports the pointer value to adopt on a handshake.
// Ports:
//   req_i      request vector
//   ptr_i      current round-robin pointer
//   gnt_o      one-hot grant (all zero when no request)
//   nxt_ptr_o  winner+1 mod N_REQ (ptr_i when no request)
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] nxt_ptr_o
);
  always_comb begin
    logic found;
    int   idx;
    gnt_o     = '0;
    nxt_ptr_o = ptr_i;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        nxt_ptr_o  = PTR_W'((idx + 1) % N_REQ);
      end
    end
  end
endmodule

// File: rtl/mem_1r1w_arbiter.sv
// Purpose: shares one masked 1R1W memory between N_REQ requesters with
// independent round-robin write and read arbitration, a same-address
// read/write interlock and a bounded-starvation override for reads.
// Ports:
//   clock, reset_n               clock, synchronous active-low reset
//   wr_valid/wr_ready            per-requester write handshake
//   wr_addr/wr_data/wr_mask      packed per-requester write fields
//   rd_valid/rd_ready            per-requester read handshake
//   rd_addr                      packed per-requester read address
//   rd_resp_valid                one-hot response strobe, 1 cycle after grant
//   rd_resp_data                 shared response data bus
module mem_1r1w_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         wr_valid,
  output logic [N_REQ-1:0]         wr_ready,
  input  logic [N_REQ*ADDR_W-1:0]  wr_addr,
  input  logic [N_REQ*DATA_W-1:0]  wr_data,
  input  logic [N_REQ*MASK_W-1:0]  wr_mask,
  input  logic [N_REQ-1:0]         rd_valid,
  output logic [N_REQ-1:0]         rd_ready,
  input  logic [N_REQ*ADDR_W-1:0]  rd_addr,
  output logic [N_REQ-1:0]         rd_resp_valid,
  output logic [DATA_W-1:0]        rd_resp_data
);
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, wnxt, rnxt;
  logic [1:0]        block_cnt_q, block_cnt_d;
  logic [N_REQ-1:0]  resp_sel_q, resp_sel_d;
  logic [N_REQ-1:0]  wgnt_c, rgnt_c;
  logic [PTR_W-1:0]  widx, ridx;
  logic [ADDR_W-1:0] waddr_c, raddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [MASK_W-1:0] wmask_c;
  logic              collide, rd_win, wr_fire, rd_fire;

  rr_arbiter #(.N_REQ(N_REQ)) u_wr_arb (
    .req_i(wr_valid), .ptr_i(wptr_q), .gnt_o(wgnt_c), .nxt_ptr_o(wnxt)
  );

  rr_arbiter #(.N_REQ(N_REQ)) u_rd_arb (
    .req_i(rd_valid), .ptr_i(rptr_q), .gnt_o(rgnt_c), .nxt_ptr_o(rnxt)
  );

  // Candidate indices drive the packed-bus muxes.
  always_comb begin
    widx = '0;
    ridx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wgnt_c[i]) widx = PTR_W'(i);
      if (rgnt_c[i]) ridx = PTR_W'(i);
    end
  end

  assign waddr_c = wr_addr[int'(widx)*ADDR_W +: ADDR_W];
  assign wdata_c = wr_data[int'(widx)*DATA_W +: DATA_W];
  assign wmask_c = wr_mask[int'(widx)*MASK_W +: MASK_W];
  assign raddr_c = rd_addr[int'(ridx)*ADDR_W +: ADDR_W];

  always_comb begin
    // A zero-mask write changes nothing, so it cannot make a read stale.
    collide = (|wgnt_c) && (|rgnt_c) && (waddr_c == raddr_c) && (|wmask_c);
    // After BLOCK_THR withheld reads the read takes the slot instead.
    rd_win  = collide && (block_cnt_q == BLOCK_THR);

    wr_ready = '0;
    rd_ready = '0;
    if (reset_n) begin
      wr_ready = rd_win ? '0 : wgnt_c;
      rd_ready = (collide && !rd_win) ? '0 : rgnt_c;
    end

    wr_fire = |wr_ready;
    rd_fire = |rd_ready;

    wptr_d = wr_fire ? wnxt : wptr_q;
    rptr_d = rd_fire ? rnxt : rptr_q;

    block_cnt_d = block_cnt_q;
    if (rd_fire)                               block_cnt_d = 2'd0;
    else if (reset_n && collide && !rd_win)    block_cnt_d = block_cnt_q + 2'd1;

    resp_sel_d = rd_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      block_cnt_q <= '0;
      resp_sel_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      block_cnt_q <= block_cnt_d;
      resp_sel_q  <= resp_sel_d;
    end
  end

  assign rd_resp_valid = resp_sel_q;

  mem_1r1w_masked #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) u_mem (
    .clk_i   (clock),
    .we_i    (wr_fire),
    .waddr_i (waddr_c),
    .wdata_i (wdata_c),
    .wmask_i (wmask_c),
    .re_i    (rd_fire),
    .raddr_i (raddr_c),
    .rdata_o (rd_resp_data)
  );
endmodule

// File: tb/tb_mem_1r1w_arbiter.sv
module tb_mem_1r1w_arbiter;
  localparam int N = 2, AW = 5, DW = 64, MW = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rd_resp_valid;
  logic [N*AW-1:0] wr_addr, rd_addr;
  logic [N*DW-1:0] wr_data;
  logic [N*MW-1:0] wr_mask;
  logic [DW-1:0]   rd_resp_data;

  int total = 0;
  int bad   = 0;

  mem_1r1w_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_valid = '0; rd_valid = '0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_valid[i] = 1'b1;
    wr_addr[i*AW +: AW] = a;
    wr_data[i*DW +: DW] = d;
    wr_mask[i*MW +: MW] = m;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_valid[i] = 1'b1;
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    set_wr(0, 5'd1, 64'h1, 8'hFF); set_wr(1, 5'd2, 64'h2, 8'hFF);
    set_rd(0, 5'd4); set_rd(1, 5'd6);
    #1;
    total++; if (wr_ready !== 2'b00) begin bad++; $display("FAIL reset_wr_ready got=%b exp=00", wr_ready); end
    total++; if (rd_ready !== 2'b00) begin bad++; $display("FAIL reset_rd_ready got=%b exp=00", rd_ready); end
    tick(); tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b exp=00", rd_resp_valid); end
    idle();
    reset_n = 1'b1;
    tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL post_reset_resp_valid got=%b exp=00", rd_resp_valid); end
  endtask

  task automatic test_write_read();
    idle();
    set_wr(0, 5'd3, 64'h1122334455667788, 8'hFF);
    #1;
    total++; if (wr_ready !== 2'b01) begin bad++; $display("FAIL wr_basic_ready got=%b exp=01", wr_ready); end
    tick();
    idle();
    set_rd(1, 5'd3);
    #1;
    total++; if (rd_ready !== 2'b10) begin bad++; $display("FAIL rd_basic_ready got=%b exp=10", rd_ready); end
    tick();
    idle();
    total++; if (rd_resp_valid !== 2'b10) begin bad++; $display("FAIL rd_basic_valid got=%b exp=10", rd_resp_valid); end
    total++; if (rd_resp_data !== 64'h1122334455667788) begin bad++; $display("FAIL rd_basic_data got=%h exp=1122334455667788", rd_resp_data); end
    tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL rd_basic_single got=%b exp=00", rd_resp_valid); end
  endtask

  task automatic test_partial_mask();
    idle(); set_wr(0, 5'd5, 64'hFFFFFFFFFFFFFFFF, 8'hFF); tick();
    idle(); set_wr(0, 5'd5, 64'h0, 8'h0F); tick();
    idle(); set_rd(0, 5'd5); tick();
    idle();
    total++; if (rd_resp_valid !== 2'b01) begin bad++; $display("FAIL partial_valid got=%b exp=01", rd_resp_valid); end
    total++; if (rd_resp_data !== 64'hFFFFFFFF00000000) begin bad++; $display("FAIL partial_data got=%h exp=ffffffff00000000", rd_resp_data); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      set_wr(0, 5'd10, 64'hA0 + 64'(c), 8'hFF);
      set_wr(1, 5'd11, 64'hB0 + 64'(c), 8'hFF);
      #1;
      exp = (c % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (wr_ready !== exp) begin bad++; $display("FAIL rr_wr cyc=%0d got=%b exp=%b", c, wr_ready, exp); end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      idle();
      set_rd(0, 5'd10); set_rd(1, 5'd11);
      #1;
      exp = (c % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (rd_ready !== exp) begin bad++; $display("FAIL rr_rd cyc=%0d got=%b exp=%b", c, rd_ready, exp); end
      tick();
      total++; if (rd_resp_valid !== exp) begin bad++; $display("FAIL rr_resp cyc=%0d got=%b exp=%b", c, rd_resp_valid, exp); end
    end
    // Last written values: req0 wrote A4 to addr 10, req1 wrote B5 to addr 11.
    total++; if (rd_resp_data !== 64'hB5) begin bad++; $display("FAIL rr_last_data got=%h exp=b5", rd_resp_data); end
    idle();
    tick();
  endtask

  task automatic test_collision();
    idle();
    set_wr(0, 5'd7, 64'hDEADBEEFCAFEF00D, 8'hFF);
    set_rd(1, 5'd7);
    #1;
    total++; if (wr_ready !== 2'b01) begin bad++; $display("FAIL coll_wr got=%b exp=01", wr_ready); end
    total++; if (rd_ready !== 2'b00) begin bad++; $display("FAIL coll_rd_held got=%b exp=00", rd_ready); end
    tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL coll_no_resp got=%b exp=00", rd_resp_valid); end
    idle();
    set_rd(1, 5'd7);
    #1;
    total++; if (rd_ready !== 2'b10) begin bad++; $display("FAIL coll_rd_retry got=%b exp=10", rd_ready); end
    tick();
    total++; if (rd_resp_data !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL coll_data got=%h exp=deadbeefcafef00d", rd_resp_data); end
    // Zero-mask write to the same address is not a collision.
    idle();
    set_wr(0, 5'd7, 64'h0, 8'h00);
    set_rd(1, 5'd7);
    #1;
    total++; if ({wr_ready, rd_ready} !== 4'b0110) begin bad++; $display("FAIL mask0_both got=%b exp=0110", {wr_ready, rd_ready}); end
    tick();
    idle();
    total++; if (rd_resp_data !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL mask0_data got=%h exp=deadbeefcafef00d", rd_resp_data); end
    tick();
  endtask

  task automatic test_starvation();
    logic [N-1:0] exp_w [4];
    logic [N-1:0] exp_r [4];
    exp_w = '{2'b01, 2'b01, 2'b00, 2'b01};
    exp_r = '{2'b00, 2'b00, 2'b10, 2'b00};
    for (int c = 0; c < 4; c++) begin
      idle();
      set_wr(0, 5'd9, 64'hA1 + 64'(c), 8'hFF);
      set_rd(1, 5'd9);
      #1;
      total++; if (wr_ready !== exp_w[c]) begin bad++; $display("FAIL starve_wr cyc=%0d got=%b exp=%b", c, wr_ready, exp_w[c]); end
      total++; if (rd_ready !== exp_r[c]) begin bad++; $display("FAIL starve_rd cyc=%0d got=%b exp=%b", c, rd_ready, exp_r[c]); end
      tick();
      if (c == 2) begin
        // Writes of A1, A2 landed; A3 was withheld, so the read sees A2.
        total++; if (rd_resp_valid !== 2'b10) begin bad++; $display("FAIL starve_valid got=%b exp=10", rd_resp_valid); end
        total++; if (rd_resp_data !== 64'hA2) begin bad++; $display("FAIL starve_data got=%h exp=a2", rd_resp_data); end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_pending();
    idle();
    set_rd(0, 5'd3);
    #1;
    total++; if (rd_ready !== 2'b01) begin bad++; $display("FAIL rstp_rd got=%b exp=01", rd_ready); end
    tick();
    reset_n = 1'b0;
    set_wr(1, 5'd3, 64'h55, 8'hFF);
    set_rd(1, 5'd4);
    #1;
    total++; if ({wr_ready, rd_ready} !== 4'b0000) begin bad++; $display("FAIL rstp_ready got=%b exp=0000", {wr_ready, rd_ready}); end
    tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL rstp_resp got=%b exp=00", rd_resp_valid); end
    idle();
    reset_n = 1'b1;
    tick();
    total++; if (rd_resp_valid !== 2'b00) begin bad++; $display("FAIL rstp_after got=%b exp=00", rd_resp_valid); end
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    test_reset();
    test_write_read();
    test_partial_mask();
    test_round_robin();
    test_collision();
    test_starvation();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
